// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: start/clear, free run, single step, drain on HALT.
// Outputs are a Moore decode of the state register; the cycle counter saturates.
module pipe_ctrl #(
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic             modo_paso,
    input  logic             paso,
    input  logic             halt_id,
    output logic             pipe_clr,
    output logic             pc_en,
    output logic             pipe_en,
    output logic             burbuja,
    output logic             done,
    output logic [CNT_W-1:0] ciclos,
    output logic [2:0]       estado
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLEAR     = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_STEP_WAIT = 3'd3;
    localparam logic [2:0] ST_STEP_ONE  = 3'd4;
    localparam logic [2:0] ST_DRAIN     = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    localparam int            DW         = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DEPTH - 2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(1);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic             inicio_q;
    logic             paso_q;
    logic             inicio_ev_s;
    logic             paso_ev_s;
    logic [DW-1:0]    drain_cnt_r;
    logic [CNT_W-1:0] ciclos_r;
    logic             count_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    assign inicio_ev_s = inicio & ~inicio_q;
    assign paso_ev_s   = paso & ~paso_q;

    // Registered copies of the request inputs for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inicio_q <= 1'b0;
            paso_q   <= 1'b0;
        end else begin
            inicio_q <= inicio;
            paso_q   <= paso;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; inicio edge always wins, then halt, then paso, then modo_paso.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (inicio_ev_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (inicio_ev_s) begin
                    state_nxt_s = ST_CLEAR;
                end else if (modo_paso) begin
                    state_nxt_s = ST_STEP_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (inicio_ev_s) begin
                    state_nxt_s = ST_CLEAR;
                end else if (halt_id) begin
                    state_nxt_s = ST_DRAIN;
                end else if (modo_paso) begin
                    state_nxt_s = ST_STEP_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STEP_WAIT: begin
                if (inicio_ev_s) begin
                    state_nxt_s = ST_CLEAR;
                end else if (paso_ev_s) begin
                    state_nxt_s = ST_STEP_ONE;
                end else if (!modo_paso) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STEP_WAIT;
                end
            end
            ST_STEP_ONE: begin
                if (inicio_ev_s) begin
                    state_nxt_s = ST_CLEAR;
                end else if (halt_id) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_STEP_WAIT;
                end
            end
            ST_DRAIN: begin
                // The last drain cycle is the one whose decrement reaches zero.
                if (inicio_ev_s) begin
                    state_nxt_s = ST_CLEAR;
                end else if (drain_cnt_r <= DRAIN_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (inicio_ev_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Drain counter: loaded on entry to DRAIN, counts down inside, zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_r <= '0;
        end else if ((state_nxt_s == ST_DRAIN) && (state_r != ST_DRAIN)) begin
            drain_cnt_r <= DRAIN_LOAD;
        end else if ((state_r == ST_DRAIN) && (drain_cnt_r != '0)) begin
            drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
        end else if (state_r != ST_DRAIN) begin
            drain_cnt_r <= '0;
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    assign count_s = (state_r == ST_RUN) || (state_r == ST_STEP_ONE) || (state_r == ST_DRAIN);

    // Cycle counter; zeroed on the way into CLEAR so it reads 0 throughout CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ciclos_r <= '0;
        end else if (state_nxt_s == ST_CLEAR) begin
            ciclos_r <= '0;
        end else if (count_s) begin
            ciclos_r <= sat_inc(ciclos_r);
        end else begin
            ciclos_r <= ciclos_r;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        pipe_clr = 1'b0;
        pc_en    = 1'b0;
        pipe_en  = 1'b0;
        burbuja  = 1'b0;
        done     = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                pipe_clr = 1'b1;
            end
            ST_RUN, ST_STEP_ONE: begin
                pc_en   = 1'b1;
                pipe_en = 1'b1;
            end
            ST_DRAIN: begin
                pipe_en = 1'b1;
                burbuja = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                pipe_clr = 1'b0;
            end
        endcase
    end

    assign ciclos = ciclos_r;
    assign estado = state_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (CNT_W=4 so saturation is reachable quickly).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst_n;
    logic       inicio;
    logic       modo_paso;
    logic       paso;
    logic       halt_id;
    logic       pipe_clr;
    logic       pc_en;
    logic       pipe_en;
    logic       burbuja;
    logic       done;
    logic [3:0] ciclos;
    logic [2:0] estado;

    int n_assert;
    int n_fail;

    pipe_ctrl #(.PIPE_DEPTH(5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .modo_paso(modo_paso),
        .paso(paso), .halt_id(halt_id), .pipe_clr(pipe_clr), .pc_en(pc_en),
        .pipe_en(pipe_en), .burbuja(burbuja), .done(done), .ciclos(ciclos),
        .estado(estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_assert++; if (estado !== 3'd0) begin n_fail++; $display("FAIL reset_estado got=%0d exp=0", estado); end
        n_assert++; if ({pipe_clr, pc_en, pipe_en, burbuja, done} !== 5'b00000) begin n_fail++; $display("FAIL reset_outs got=%b exp=00000", {pipe_clr, pc_en, pipe_en, burbuja, done}); end
        n_assert++; if (ciclos !== 4'd0) begin n_fail++; $display("FAIL reset_ciclos got=%0d exp=0", ciclos); end
    endtask

    task automatic test_start;
        inicio = 1'b1; modo_paso = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++; if (estado !== 3'd1 || pipe_clr !== 1'b1) begin n_fail++; $display("FAIL start_clear got estado=%0d clr=%b exp 1/1", estado, pipe_clr); end
        @(negedge clk);
        n_assert++; if (estado !== 3'd2 || pipe_clr !== 1'b0 || pc_en !== 1'b1 || pipe_en !== 1'b1) begin n_fail++; $display("FAIL start_run got estado=%0d clr=%b pc=%b pe=%b exp 2/0/1/1", estado, pipe_clr, pc_en, pipe_en); end
        @(negedge clk);
        n_assert++; if (ciclos !== 4'd1) begin n_fail++; $display("FAIL start_ciclos got=%0d exp=1", ciclos); end
    endtask

    task automatic test_halt_drain;
        repeat (8) @(negedge clk);
        n_assert++; if (estado !== 3'd2 || ciclos !== 4'd9) begin n_fail++; $display("FAIL run10 got estado=%0d ciclos=%0d exp 2/9", estado, ciclos); end
        halt_id = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            halt_id = 1'b0;
            n_assert++; if (estado !== 3'd5 || burbuja !== 1'b1 || pc_en !== 1'b0 || pipe_en !== 1'b1 || ciclos !== 4'(10 + k)) begin
                n_fail++; $display("FAIL drain_%0d got estado=%0d bub=%b pc=%b pe=%b ciclos=%0d exp 5/1/0/1/%0d", k, estado, burbuja, pc_en, pipe_en, ciclos, 10 + k);
            end
        end
        @(negedge clk);
        halt_id = 1'b1;
        n_assert++; if (estado !== 3'd6 || done !== 1'b1 || ciclos !== 4'd13 || pipe_en !== 1'b0) begin n_fail++; $display("FAIL done got estado=%0d done=%b ciclos=%0d pe=%b exp 6/1/13/0", estado, done, ciclos, pipe_en); end
        repeat (2) @(negedge clk);
        halt_id = 1'b0;
        n_assert++; if (estado !== 3'd6 || ciclos !== 4'd13) begin n_fail++; $display("FAIL done_hold got estado=%0d ciclos=%0d exp 6/13", estado, ciclos); end
    endtask

    task automatic test_step;
        inicio = 1'b0; modo_paso = 1'b1;
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        n_assert++; if (estado !== 3'd1 || ciclos !== 4'd0) begin n_fail++; $display("FAIL step_clear got estado=%0d ciclos=%0d exp 1/0", estado, ciclos); end
        @(negedge clk);
        n_assert++; if (estado !== 3'd3 || pipe_en !== 1'b0 || ciclos !== 4'd0) begin n_fail++; $display("FAIL step_wait0 got estado=%0d pe=%b ciclos=%0d exp 3/0/0", estado, pipe_en, ciclos); end
        for (int p = 0; p < 3; p++) begin
            paso = 1'b1;
            @(negedge clk);
            paso = 1'b0;
            n_assert++; if (estado !== 3'd4 || pipe_en !== 1'b1 || pc_en !== 1'b1) begin n_fail++; $display("FAIL step_one_%0d got estado=%0d pe=%b pc=%b exp 4/1/1", p, estado, pipe_en, pc_en); end
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                halt_id = (w == 1);
                n_assert++; if (estado !== 3'd3 || pipe_en !== 1'b0 || ciclos !== 4'(p + 1)) begin
                    n_fail++; $display("FAIL step_gap_%0d_%0d got estado=%0d pe=%b ciclos=%0d exp 3/0/%0d", p, w, estado, pipe_en, ciclos, p + 1);
                end
            end
            halt_id = 1'b0;
        end
    endtask

    task automatic test_abort_drain;
        modo_paso = 1'b0; inicio = 1'b0;
        @(negedge clk);
        n_assert++; if (estado !== 3'd2 || ciclos !== 4'd3) begin n_fail++; $display("FAIL abort_run got estado=%0d ciclos=%0d exp 2/3", estado, ciclos); end
        halt_id = 1'b1;
        @(negedge clk);
        halt_id = 1'b0;
        n_assert++; if (estado !== 3'd5 || ciclos !== 4'd4) begin n_fail++; $display("FAIL abort_drain1 got estado=%0d ciclos=%0d exp 5/4", estado, ciclos); end
        @(negedge clk);
        n_assert++; if (estado !== 3'd5 || ciclos !== 4'd5) begin n_fail++; $display("FAIL abort_drain2 got estado=%0d ciclos=%0d exp 5/5", estado, ciclos); end
        inicio = 1'b1;
        @(negedge clk);
        n_assert++; if (estado !== 3'd1 || ciclos !== 4'd0 || pipe_clr !== 1'b1 || burbuja !== 1'b0) begin n_fail++; $display("FAIL abort_clear got estado=%0d ciclos=%0d clr=%b bub=%b exp 1/0/1/0", estado, ciclos, pipe_clr, burbuja); end
        @(negedge clk);
        n_assert++; if (estado !== 3'd2 || ciclos !== 4'd0) begin n_fail++; $display("FAIL abort_rerun got estado=%0d ciclos=%0d exp 2/0", estado, ciclos); end
        repeat (4) @(negedge clk);
        n_assert++; if (estado !== 3'd2 || ciclos !== 4'd4 || done !== 1'b0) begin n_fail++; $display("FAIL abort_nodone got estado=%0d ciclos=%0d done=%b exp 2/4/0", estado, ciclos, done); end
    endtask

    task automatic test_saturate;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_assert++; if (ciclos !== 4'd15 || estado !== 3'd2) begin n_fail++; $display("FAIL sat_%0d got ciclos=%0d estado=%0d exp 15/2", k, ciclos, estado); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset;
        #2 rst_n = 1'b0;
        #1;
        n_assert++; if (estado !== 3'd0 || {pipe_clr, pc_en, pipe_en, burbuja, done} !== 5'b00000 || ciclos !== 4'd0) begin
            n_fail++; $display("FAIL areset_run got estado=%0d outs=%b ciclos=%0d exp 0/00000/0", estado, {pipe_clr, pc_en, pipe_en, burbuja, done}, ciclos);
        end
        inicio = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        n_assert++; if (estado !== 3'd1) begin n_fail++; $display("FAIL areset_restart got estado=%0d exp 1", estado); end
        @(negedge clk);
        halt_id = 1'b1;
        @(negedge clk);
        halt_id = 1'b0;
        n_assert++; if (estado !== 3'd5) begin n_fail++; $display("FAIL areset_predrain got estado=%0d exp 5", estado); end
        #2 rst_n = 1'b0;
        #1;
        n_assert++; if (estado !== 3'd0 || burbuja !== 1'b0 || pipe_en !== 1'b0) begin n_fail++; $display("FAIL areset_drain got estado=%0d bub=%b pe=%b exp 0/0/0", estado, burbuja, pipe_en); end
        inicio = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_assert++; if (estado !== 3'd0 || done !== 1'b0 || ciclos !== 4'd0) begin n_fail++; $display("FAIL areset_nopartial got estado=%0d done=%b ciclos=%0d exp 0/0/0", estado, done, ciclos); end
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst_n = 1'b0; inicio = 1'b0; modo_paso = 1'b0; paso = 1'b0; halt_id = 1'b0;
        test_reset();
        test_start();
        test_halt_drain();
        test_step();
        test_abort_drain();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
